serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
//
// PURPOSE
// Sequences one full_adder cell over WIDTH clock cycles to add two WIDTH-bit operands
// bit-serially, LSB first, with a carry flip-flop between bits.
// Sits between a requester (start/done handshake) and the 1-bit full_adder datapath.
// Trades area for latency: one adder cell serves any operand width.
//
// PARAMETERS
// WIDTH    8    operand/result width in bits; legal range 2..32
//
// PORTS
// clk      in   1      single clock, all state updates on rising edge
// rst_n    in   1      synchronous, active-low reset
// start    in   1      request; sampled only in IDLE or DONE
// a_in     in   WIDTH  operand A, captured on the accepting edge
// b_in     in   WIDTH  operand B, captured on the accepting edge
// C_in     in   1      carry-in, captured on the accepting edge
// busy     out  1      high while bits are being processed (SHIFT state)
// done     out  1      one-cycle pulse: Sum/C_out hold a new result
// Sum      out  WIDTH  result register; changes only when done rises
// C_out    out  1      final carry; changes only when done rises
//
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, Sum=0, C_out=0,
//   operand shifters, carry FF and bit counter cleared. Reset mid-operation aborts;
//   no done pulse is issued for the aborted request.
// - States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:  start=1 -> load a_sh<=a_in, b_sh<=b_in, cy<=C_in, cnt<=0; go SHIFT.
//   SHIFT: busy=1. Each edge: full_adder(a_sh[0], b_sh[0], cy) -> (s, co);
//          s_sh <= {s, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right; cy<=co; cnt<=cnt+1.
//          On the edge with cnt==WIDTH-1: Sum<={s, s_sh[WIDTH-1:1]}, C_out<=co; go DONE.
//   DONE:  done=1, busy=0 for exactly one cycle. start=1 -> load as in IDLE, go SHIFT
//          (back-to-back, no idle bubble); else go IDLE.
// - Latency: start sampled at edge k -> busy high after k..k+WIDTH-1 edges;
//   done high in the cycle after edge k+WIDTH. Throughput: one add per WIDTH+1 cycles.
// - start while busy=1 is ignored (not queued); a_in/b_in/C_in may change freely then.
// - Arithmetic: {C_out, Sum} = a_in + b_in + C_in, modulo 2^(WIDTH+1); unsigned.
// - Counter width clog2(WIDTH); it never wraps (leaves SHIFT at WIDTH-1).
// - Sum/C_out hold the last completed result through IDLE and following SHIFT.
// - busy and done are never high together; both are registered state decodes.
//
// STRUCTURE
// - Package serial_add_pkg: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
//   default width constant SA_WIDTH=8.
// - One sub-module instance: full_adder (existing 1-bit cell: a, b, C_in -> Sum, C_out),
//   instanced once; all control, shifters and carry FF live in serial_add_ctrl.
// - Unused state encoding 2'd3 decodes to IDLE on the next edge.
//
// TESTING (WIDTH=8, bench serial_add_stimuli)
// 1. Reset held 3 cycles -> busy=0, done=0, Sum=8'h00, C_out=0.
// 2. a=8'h3C, b=8'h0F, C_in=0, start pulse -> busy 8 cycles, done pulse, Sum=8'h4B, C_out=0.
// 3. a=8'hFF, b=8'h01, C_in=0 -> Sum=8'h00, C_out=1; then a=8'hA5, b=8'h5A, C_in=1 -> Sum=8'h00, C_out=1.
// 4. start re-pulsed with a=8'h11 during busy of a=8'h01+b=8'h02 -> ignored; Sum=8'h03, one done only.
// 5. start held high through DONE with a=8'h10, b=8'h20 -> next SHIFT begins immediately; Sum=8'h30.
// 6. rst_n=0 at 4th SHIFT edge -> no done pulse, Sum=8'h00; next request completes normally.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared encodings and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic C_in,
    output logic Sum,
    output logic C_out
);

    assign Sum   = a ^ b ^ C_in;
    assign C_out = (a & b) | (C_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell reused over WIDTH cycles, LSB first,
// with a carry flip-flop between bits and a start/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             C_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;

    logic             fa_s, fa_co;
    logic             accept;
    logic [WIDTH-1:0] sum_word;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .C_in  (cy_q),
        .Sum   (fa_s),
        .C_out (fa_co)
    );

    // A request is only taken when no add is in flight.
    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    // The partial sum is one bit short; the current cell output completes it.
    assign sum_word = {fa_s, s_sh_q};

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = (cnt_q == LAST) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        if (state_q == ST_SHIFT) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            s_sh_d = sum_word[WIDTH-1:1];
            cy_d   = fa_co;
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                sum_d   = sum_word;
                c_out_d = fa_co;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (accept) begin
            a_sh_d = a_in;
            b_sh_d = b_in;
            s_sh_d = '0;
            cy_d   = C_in;
            cnt_d  = '0;
        end
    end

    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign Sum   = sum_q;
    assign C_out = c_out_q;

endmodule
